// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between
// the ALU result path and the load-return path. Uncontested requests are
// granted immediately; contested cycles alternate round-robin. The granted
// request is presented to the register file one cycle later.
module wb_port_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              mem_valid,
    input  logic [4:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,

    output logic              RegWrite,
    output logic [4:0]        WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int unsigned   RD_W    = 5;
    localparam logic [RD_W-1:0]  XZR     = 5'd31;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Which requester won the most recent contested cycle.
    typedef enum logic {
        LG_ALU = 1'b0,
        LG_MEM = 1'b1
    } grant_t;

    grant_t            last_grant;
    logic              contested;
    logic              grant_alu;
    logic              grant_mem;
    logic              grant_any;
    logic              grant_writes;
    logic [RD_W-1:0]   grant_rd;
    logic [DATA_W-1:0] grant_data;

    // Grant selection: single requester wins outright, contested cycles go
    // to the side that did not win the previous contested cycle.
    always_comb begin
        contested    = alu_valid & mem_valid;
        grant_alu    = 1'b0;
        grant_mem    = 1'b0;
        if (!reset) begin
            if (contested) begin
                grant_alu = (last_grant == LG_MEM);
                grant_mem = (last_grant == LG_ALU);
            end else begin
                grant_alu = alu_valid;
                grant_mem = mem_valid;
            end
        end
        grant_any    = grant_alu | grant_mem;
        grant_rd     = grant_mem ? mem_rd   : alu_rd;
        grant_data   = grant_mem ? mem_data : alu_data;
        // Writes to XZR complete the handshake but never reach the file.
        grant_writes = grant_any & (grant_rd != XZR);
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    // Register-file write stage: one pulse per real grant, address/data held
    // between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= grant_writes;
            if (grant_writes) begin
                WriteReg  <= grant_rd;
                WriteData <= grant_data;
            end
        end
    end

    // Round-robin pointer only moves on contested grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= LG_MEM;
        end else if (contested) begin
            last_grant <= grant_alu ? LG_ALU : LG_MEM;
        end
    end

    // Saturating count of cycles with both requesters valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (contested && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based model of grants and writes.
module tb_wb_port_arbiter;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned CNT_W   = 8;
    localparam longint      CNT_MAX = (64'd1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              alu_valid = 1'b0;
    logic [4:0]        alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              alu_ready;
    logic              mem_valid = 1'b0;
    logic [4:0]        mem_rd = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              mem_ready;
    logic              RegWrite;
    logic [4:0]        WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [CNT_W-1:0]  conflict_cnt;

    wb_port_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        rd;
        logic [DATA_W-1:0] d;
    } wr_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     contested_n = 0;   // contested cycles since reset: even -> ALU wins
    longint cnt_m = 0;
    wr_t    exp_q[$];
    bit     got_ar, got_mr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        contested_n = 0;
        cnt_m = 0;
        exp_q.delete();
    endtask

    // One cycle: drive requests, check readies, clock, check write stage.
    task automatic step(input bit av, input logic [4:0] ard, input logic [DATA_W-1:0] ad,
                        input bit mv, input logic [4:0] mrd, input logic [DATA_W-1:0] md);
        bit  ga, gm;
        wr_t w;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #1;
        ga = av && (!mv || (contested_n % 2 == 0));
        gm = mv && (!av || (contested_n % 2 == 1));
        got_ar = alu_ready;
        got_mr = mem_ready;
        chk("alu_ready", 64'(alu_ready), 64'(ga));
        chk("mem_ready", 64'(mem_ready), 64'(gm));
        if (av && mv) begin
            contested_n++;
            if (cnt_m < CNT_MAX) cnt_m++;
        end
        if (ga && ard != 5'd31) exp_q.push_back('{ard, ad});
        if (gm && mrd != 5'd31) exp_q.push_back('{mrd, md});
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("RegWrite", 64'(RegWrite), 64'(1));
            chk("WriteReg", 64'(WriteReg), 64'(w.rd));
            chk("WriteData", 64'(WriteData), 64'(w.d));
        end else begin
            chk("RegWrite_idle", 64'(RegWrite), 64'(0));
        end
        chk("conflict_cnt", 64'(conflict_cnt), 64'(cnt_m));
    endtask

    // Reset with both requesters active to show readies are suppressed.
    task automatic do_reset();
        reset = 1'b1;
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        chk("rst_alu_ready", 64'(alu_ready), 64'(0));
        chk("rst_mem_ready", 64'(mem_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_RegWrite", 64'(RegWrite), 64'(0));
        chk("rst_WriteReg", 64'(WriteReg), 64'(0));
        chk("rst_WriteData", 64'(WriteData), 64'(0));
        chk("rst_conflict_cnt", 64'(conflict_cnt), 64'(0));
        alu_valid = 1'b0; mem_valid = 1'b0;
        reset = 1'b0;
        clear_model();
    endtask

    initial begin
        bit                a_hold, m_hold, av, mv;
        logic [4:0]        ard, mrd;
        logic [DATA_W-1:0] ad, md;
        bit                gseq[4];

        @(posedge clk);
        #1;
        do_reset();

        // Single ALU request granted in the first cycle after reset.
        step(1, 5'd5, 64'h1234, 0, 5'd0, 64'h0);
        chk("r33_ready", 64'(got_ar), 64'(1));
        chk("r33_RegWrite", 64'(RegWrite), 64'(1));
        chk("r33_WriteReg", 64'(WriteReg), 64'(5));
        chk("r33_WriteData", 64'(WriteData), 64'h1234);
        step(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
        chk("r33_single_pulse", 64'(RegWrite), 64'(0));

        // Contested round-robin after reset: ALU, MEM, ALU, MEM.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 5'd1, 64'(100 + i), 1, 5'd2, 64'(200 + i));
            gseq[i] = got_ar;
            chk("r34_RegWrite", 64'(RegWrite), 64'(1));
        end
        chk("r34_g0_alu", 64'(gseq[0]), 64'(1));
        chk("r34_g1_mem", 64'(gseq[1]), 64'(0));
        chk("r34_g2_alu", 64'(gseq[2]), 64'(1));
        chk("r34_g3_mem", 64'(gseq[3]), 64'(0));
        chk("r34_cnt", 64'(conflict_cnt), 64'(4));

        // Load to XZR: accepted but not written.
        step(0, 5'd0, 64'h0, 1, 5'd31, 64'hFF);
        chk("r35_ready", 64'(got_mr), 64'(1));
        chk("r35_RegWrite", 64'(RegWrite), 64'(0));

        // Uncontested grants leave the pointer alone: next contested goes to ALU
        // (4 contested cycles so far -> even).
        step(1, 5'd9, 64'h99, 0, 5'd0, 64'h0);
        step(1, 5'd3, 64'h33, 1, 5'd3, 64'h44);
        chk("r22_alu_wins", 64'(got_ar), 64'(1));
        step(0, 5'd0, 64'h0, 1, 5'd3, 64'h44);
        chk("r28_second_write", 64'(WriteData), 64'h44);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < (1 << CNT_W) + 5; i++)
            step(1, 5'(i), 64'(i), 1, 5'(i + 1), 64'(i * 3));
        chk("r36_saturated", 64'(conflict_cnt), 64'hFF);

        // Reset between grant and presentation discards the write.
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hABCD;
        #1;
        chk("r37_ready", 64'(alu_ready), 64'(1));
        #1;
        reset = 1'b1;
        #1;
        chk("r37_RegWrite_rst", 64'(RegWrite), 64'(0));
        alu_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("r37_RegWrite_hold", 64'(RegWrite), 64'(0));
        chk("r37_WriteReg", 64'(WriteReg), 64'(0));
        chk("r37_WriteData", 64'(WriteData), 64'(0));
        reset = 1'b0;
        clear_model();
        step(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
        chk("r37_after_release", 64'(RegWrite), 64'(0));

        // Randomized traffic; a refused requester holds its request.
        do_reset();
        a_hold = 0; m_hold = 0;
        av = 0; mv = 0; ard = '0; mrd = '0; ad = '0; md = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!a_hold) begin
                av  = ($urandom_range(0, 3) != 0);
                ard = 5'($urandom_range(0, 31));
                ad  = {$urandom, $urandom};
            end
            if (!m_hold) begin
                mv  = ($urandom_range(0, 2) != 0);
                mrd = 5'($urandom_range(0, 31));
                md  = {$urandom, $urandom};
            end
            step(av, ard, ad, mv, mrd, md);
            a_hold = av && !got_ar;
            m_hold = mv && !got_mr;
        end
        step(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
        chk("rand_queue_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
